// File: rtl/serial_bus_loader.sv
// Serial-to-parallel word loader: shifts in NrOfBits MSB-first bits and publishes the word with valid/ack.
// Even-parity checking (extra PARITY state) is compiled in with SERIAL_BUS_LOADER_PARITY_EN.
module serial_bus_loader #(
    parameter int NrOfBits = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                tick,
    input  logic                sstart,
    input  logic                sdata,
    output logic [NrOfBits-1:0] word,
    output logic                wordValid,
    input  logic                wordAck,
    output logic                overrun,
    output logic                parityError
);
    localparam int CW = $clog2(NrOfBits + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(NrOfBits - 1);

    // IDLE: wait for start | SHIFT: collecting bits | HOLD: word valid until ack | PARITY: await parity bit
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SHIFT  = 2'd1;
    localparam logic [1:0] HOLD   = 2'd2;
`ifdef SERIAL_BUS_LOADER_PARITY_EN
    localparam logic [1:0] PARITY = 2'd3;
`endif

    logic [1:0]          state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [NrOfBits-1:0] shift_q, shift_d;
    logic [NrOfBits-1:0] word_q, word_d;
    logic                valid_q, valid_d;
    logic                ovr_q, ovr_d;
    logic [NrOfBits-1:0] shift_in;
    logic                advance;
    logic                last_bit;
`ifdef SERIAL_BUS_LOADER_PARITY_EN
    logic                perr_q, perr_d;
`endif

    assign shift_in = (shift_q << 1) | NrOfBits'(sdata);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shift_d  = shift_q;
        word_d   = word_q;
        valid_d  = valid_q;
        ovr_d    = ovr_q;
        advance  = 1'b0;
        last_bit = 1'b0;
`ifdef SERIAL_BUS_LOADER_PARITY_EN
        perr_d   = 1'b0;
`endif
        case (state_q)
            HOLD: begin
                if (wordAck) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
                // A start seen while holding is always dropped, even alongside the ack.
                if (tick && sstart) begin
                    ovr_d = 1'b1;
                end
            end
            default: begin
                if (tick && sstart) begin
                    shift_d  = shift_in;
                    cnt_d    = CW'(1);
                    advance  = 1'b1;
                    last_bit = (NrOfBits == 1);
                end else if (tick && state_q == SHIFT) begin
                    shift_d  = shift_in;
                    cnt_d    = cnt_q + CW'(1);
                    advance  = 1'b1;
                    last_bit = (cnt_q == LAST_CNT);
                end
`ifdef SERIAL_BUS_LOADER_PARITY_EN
                else if (tick && state_q == PARITY) begin
                    if ((^shift_q ^ sdata) == 1'b0) begin
                        word_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = HOLD;
                    end else begin
                        perr_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
`endif
                if (advance) begin
                    if (last_bit) begin
`ifdef SERIAL_BUS_LOADER_PARITY_EN
                        state_d = PARITY;
`else
                        word_d  = shift_in;
                        valid_d = 1'b1;
                        state_d = HOLD;
`endif
                    end else begin
                        state_d = SHIFT;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
`ifdef SERIAL_BUS_LOADER_PARITY_EN
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            word_q  <= word_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
`ifdef SERIAL_BUS_LOADER_PARITY_EN
            perr_q  <= perr_d;
`endif
        end
    end

    assign word      = word_q;
    assign wordValid = valid_q;
    assign overrun   = ovr_q;
`ifdef SERIAL_BUS_LOADER_PARITY_EN
    assign parityError = perr_q;
`else
    assign parityError = 1'b0;
`endif

endmodule

// File: tb/tb_serial_bus_loader.sv
// Scoreboard bench for serial_bus_loader: driver pushes expected words, a negedge monitor pops and compares.
module tb_serial_bus_loader;
    logic       clock;
    logic       reset;
    logic       tick;
    logic       sstart;
    logic       sdata;
    logic [7:0] word;
    logic       wordValid;
    logic       wordAck;
    logic       overrun;
    logic       parityError;

    int n_total = 0;
    int n_pass  = 0;

    logic [7:0] exp_q[$];
    bit         m_hold    = 1'b0;
    bit         m_overrun = 1'b0;

    logic [7:0] exp_word   = 8'h00;
    logic       prev_valid = 1'b0;
    logic       rst_prev   = 1'b1;

    serial_bus_loader #(.NrOfBits(8)) dut (
        .clock      (clock),
        .reset      (reset),
        .tick       (tick),
        .sstart     (sstart),
        .sdata      (sdata),
        .word       (word),
        .wordValid  (wordValid),
        .wordAck    (wordAck),
        .overrun    (overrun),
        .parityError(parityError)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: the word may only change on a fresh valid (popping the scoreboard) or after reset.
    always @(negedge clock) begin
        if (rst_prev) begin
            exp_word = 8'h00;
            check("reset_word", word, 8'h00);
            check("reset_valid", wordValid, 1'b0);
            prev_valid = 1'b0;
        end else begin
            if (wordValid && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_valid: got word %0h with no expected word queued", word);
                end else begin
                    exp_word = exp_q.pop_front();
                end
            end
            check("word_track", word, exp_word);
            prev_valid = wordValid;
        end
        rst_prev = reset;
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic bit_cyc(input logic s, input logic d, input logic a);
        tick = 1'b1; sstart = s; sdata = d; wordAck = a;
        @(posedge clock);
        #1;
        tick = 1'b0; sstart = 1'b0; sdata = 1'b0; wordAck = 1'b0;
    endtask

    task automatic do_ack();
        wordAck = 1'b1;
        @(posedge clock);
        #1;
        wordAck = 1'b0;
        m_hold = 1'b0;
        check("valid_after_ack", wordValid, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        m_hold = 1'b0;
        m_overrun = 1'b0;
        check("rst_word", word, 8'h00);
        check("rst_valid", wordValid, 1'b0);
        check("rst_overrun", overrun, 1'b0);
    endtask

    // Sends nbits of val MSB first (nbits<8 models an abandoned frame), one bit every gap cycles.
    task automatic send_frame(input logic [7:0] val, input int nbits, input int gap,
                              input bit bad_par, input bit ack_start);
        bit accept;
        accept = !m_hold;
        if (m_hold) begin
            m_overrun = 1'b1;
            if (ack_start) m_hold = 1'b0;
        end
        for (int i = 0; i < nbits; i++) begin
            if (i > 0) idle(gap - 1);
`ifndef SERIAL_BUS_LOADER_PARITY_EN
            if (accept && i == 7) begin
                exp_q.push_back(val);
                m_hold = 1'b1;
            end
`endif
            bit_cyc(i == 0, val[7 - i], ack_start && i == 0);
            if (accept && i < nbits - 1) check("valid_mid", wordValid, 1'b0);
        end
`ifdef SERIAL_BUS_LOADER_PARITY_EN
        if (nbits == 8) begin
            idle(gap - 1);
            if (accept) check("valid_pre_par", wordValid, 1'b0);
            if (accept && !bad_par) begin
                exp_q.push_back(val);
                m_hold = 1'b1;
            end
            bit_cyc(1'b0, (^val) ^ bad_par, 1'b0);
            if (accept && bad_par) begin
                check("perr_pulse", parityError, 1'b1);
                check("valid_bad_par", wordValid, 1'b0);
                idle(1);
                check("perr_clear", parityError, 1'b0);
            end
        end
`endif
        if (accept && nbits == 8 && !bad_par) begin
            check("valid_latency", wordValid, 1'b1);
            check("word_latency", word, val);
        end
    endtask

    initial begin
        reset = 1'b1; tick = 1'b0; sstart = 1'b0; sdata = 1'b0; wordAck = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        check("init_word", word, 8'h00);
        check("init_valid", wordValid, 1'b0);
        check("init_overrun", overrun, 1'b0);
        check("init_perr", parityError, 1'b0);
        idle(20);
        check("idle_word", word, 8'h00);
        check("idle_valid", wordValid, 1'b0);

        send_frame(8'hA5, 8, 1, 1'b0, 1'b0);
        idle(10);
        check("hold_valid", wordValid, 1'b1);
        check("hold_word", word, 8'hA5);
        do_ack();
        check("ack_word", word, 8'hA5);

        send_frame(8'h3C, 8, 3, 1'b0, 1'b0);
        do_ack();

        send_frame(8'hFF, 4, 1, 1'b0, 1'b0);
        check("restart_word_kept", word, 8'h3C);
        send_frame(8'h81, 8, 1, 1'b0, 1'b0);
        do_ack();

        send_frame(8'h12, 8, 1, 1'b0, 1'b0);
        send_frame(8'h34, 8, 1, 1'b0, 1'b0);
        check("ovr_set", overrun, 1'b1);
        check("ovr_word", word, 8'h12);
        check("ovr_valid", wordValid, 1'b1);
        do_ack();
        send_frame(8'h56, 8, 2, 1'b0, 1'b0);
        check("ovr_sticky", overrun, 1'b1);
        check("after_ovr_word", word, 8'h56);
        do_ack();

        send_frame(8'h99, 5, 1, 1'b0, 1'b0);
        do_reset();
        send_frame(8'h0F, 8, 1, 1'b0, 1'b0);
        do_ack();

`ifdef SERIAL_BUS_LOADER_PARITY_EN
        send_frame(8'hA5, 8, 1, 1'b0, 1'b0);
        do_ack();
        send_frame(8'hA5, 8, 1, 1'b1, 1'b0);
        check("bad_par_word", word, 8'hA5);
`endif

        for (int it = 0; it < 150; it++) begin
            logic [7:0] v;
            int         sel;
            bit         bp;
            v   = 8'($urandom);
            sel = $urandom_range(0, 9);
            bp  = 1'b0;
`ifdef SERIAL_BUS_LOADER_PARITY_EN
            bp = ($urandom_range(0, 3) == 0);
`endif
            if (sel == 0) do_reset();
            else if (sel < 3) send_frame(8'($urandom), $urandom_range(1, 7), $urandom_range(1, 3), 1'b0, 1'b0);
            if ($urandom_range(0, 2) == 0) do_ack();
            send_frame(v, 8, $urandom_range(1, 3), bp, $urandom_range(0, 3) == 0);
            idle($urandom_range(0, 3));
            check("rand_overrun", overrun, m_overrun);
            check("rand_valid", wordValid, m_hold);
        end

        idle(2);
        check("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/serial_bus_loader.md
Name: serial_bus_loader

Overview:
- Serial-to-parallel front end that assembles a NrOfBits-wide word from a 1-bit stream and presents it, stable, on a parallel bus.
- Sits directly upstream of the bitwise gate-bus stage. Its word output drives one gate operand.
- The word register updates only on frame completion, so the downstream combinational gate never sees a partially shifted value.
- Valid/ack handshake tells the consumer when a fresh word is present.

Parameters:
- NrOfBits, 8, data word width; legal range 1..64.

Ports:
- clock  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- tick  input  1  bit-strobe enable; sdata/sstart are sampled only on cycles with tick=1.
- sstart  input  1  frame start; the bit on sdata in the same tick cycle is the first data bit.
- sdata  input  1  serial data, MSB first.
- word  output  NrOfBits  last completed word (parallel bus to gate stage).
- wordValid  output  1  word is new and unacknowledged.
- wordAck  input  1  consumer acknowledge; effective only while wordValid=1.
- overrun  output  1  sticky: a frame start was dropped while in HOLD.
- parityError  output  1  one-cycle pulse on parity failure (optional feature; tied 0 when compiled out).

Behaviour:
- Reset values (reset=1 at a clock edge):
  - Outputs: word=0, wordValid=0, overrun=0, parityError=0.
  - Internal: state=IDLE, bit counter=0, shift register=0.
  - Reset has priority over every other input. A frame in progress is discarded with no partial word update.
- Bit counter width: clog2(NrOfBits+1).
- IDLE:
  - tick&sstart: shift reg <= {shift[NrOfBits-2:0], sdata}, count=1, go to SHIFT.
  - If NrOfBits==1, go to HOLD directly instead: word <= sdata, wordValid <= 1 on the same edge.
  - tick without sstart: no effect.
- SHIFT:
  - Each tick: shift sdata in at the LSB and increment count.
  - When this tick brings count to NrOfBits: word <= assembled value, wordValid <= 1, go to HOLD.
  - The first received bit lands in word[NrOfBits-1].
  - Cycles with tick=0 hold all state.
  - tick&sstart in SHIFT aborts the current frame and restarts: that bit becomes bit 1, count=1. The word output is unchanged.
- HOLD:
  - wordValid=1 and word stable.
  - wordAck=1: wordValid <= 0 on that edge, go to IDLE.
  - tick&sstart while in HOLD, without wordAck on the same cycle: frame ignored, overrun <= 1 (sticky until reset).
  - wordAck and tick&sstart on the same cycle: the ack takes effect, the start is also dropped, overrun <= 1. The next frame needs a new sstart.
- word retains its value after ack until the next completed frame. wordAck outside HOLD is ignored.
- Latency: wordValid rises on the clock edge that samples the last data bit. Back-to-back frames require ack before the next sstart.

Optional Feature:
- Macro: SERIAL_BUS_LOADER_PARITY_EN.
- When defined:
  - After the NrOfBits data bits, one further tick samples an even-parity bit; state PARITY sits between SHIFT and HOLD.
  - If XOR(data bits, parity bit)=0: word updates and wordValid rises on that edge.
  - Otherwise: word is unchanged, wordValid stays 0, parityError pulses 1 for exactly one clock, go to IDLE.
  - sstart during PARITY restarts the frame as in SHIFT.
- When undefined: no PARITY state, parityError constant 0, timing as above.

Test Plan:
- Reset then idle: reset=1 for 2 cycles -> word=0x00, wordValid=0, overrun=0. 20 cycles with tick=0 -> no change.
- Frame 8'hA5 (NrOfBits=8), MSB first, tick every cycle:
  - wordValid=1 on the 8th sampled bit, word=0xA5.
  - Held with no ack for 10 cycles -> stable.
  - wordAck=1 -> wordValid=0 next cycle, word still 0xA5.
- Sparse tick: frame 8'h3C with tick asserted every 3rd cycle -> word=0x3C after 8 ticks; no change on non-tick cycles.
- Restart: 4 bits of 0xFF, then sstart with frame 8'h81 -> word=0x81. Previous word is unchanged until completion.
- Overrun: complete 0x12, no ack, send sstart+8 bits of 0x34 -> word stays 0x12, overrun=1. Ack, then frame 0x56 -> word=0x56, overrun still 1.
- Reset mid-frame: reset after 5 bits of 0x99 -> wordValid=0, word=0x00. A following full frame 0x0F -> word=0x0F.
- Parity (with macro):
  - 0xA5 with parity bit 0 -> accepted.
  - 0xA5 with parity bit 1 -> parityError one-cycle pulse, wordValid=0, word unchanged.
